// File: rtl/seq_game_pkg.sv
// Shared constants for the sequence-memory game controller.
// Holds the FSM state encodings and the display speed ceiling.
package seq_game_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START     = 4'd1,
        ST_ADD       = 4'd2,
        ST_SHOW      = 4'd3,
        ST_SHOW_WAIT = 4'd4,
        ST_INPUT     = 4'd5,
        ST_HOLD      = 4'd6,
        ST_WIN       = 4'd7,
        ST_LOSE      = 4'd8
    } game_state_t;

    localparam logic [2:0] SPEED_MAX = 3'd7;

endpackage

// File: rtl/seq_mem.sv
// Colour sequence storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; only entries below the live length are ever read.
module seq_mem #(
    parameter int  COLOR_W = 2,
    parameter int  DEPTH   = 32,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [COLOR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [COLOR_W-1:0] rdata
);

    logic [COLOR_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/seq_game_ctrl.sv
// Sequence-memory game controller: grows a random colour sequence, replays it,
// then checks the player's button presses with an optional per-press timeout.
module seq_game_ctrl
    import seq_game_pkg::*;
#(
    parameter int  COLOR_W     = 2,
    parameter int  DEPTH       = 32,
    parameter int  TIMEOUT     = 8,
    parameter int  SPEED_SHIFT = 2,
    localparam int CNT_W       = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START_GAME,
    input  logic [COLOR_W-1:0] RAND,
    input  logic [COLOR_W-1:0] IN,
    input  logic               IN_VALID,
    input  logic               TICK,
    input  logic               TIMER_PULSE,
    output logic               TIMER_GO,
    output logic [2:0]         SPEED,
    output logic [COLOR_W-1:0] OUT,
    output logic               OUT_ENA,
    output logic [CNT_W:0]     SCORE,
    output logic [CNT_W:0]     HIGH_SCORE,
    output logic               WIN,
    output logic               LOSE,
    output logic               HS
);

    localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]  DEPTH_V = (CNT_W+1)'(DEPTH);

    game_state_t        state, state_nxt;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W:0]     len;
    logic [CNT_W:0]     len_inc;
    logic [TO_W-1:0]    tcnt;
    logic               good;
    logic               mem_we;
    logic [COLOR_W-1:0] mem_rd;
    logic               last;
    logic               full;
    logic               timeout_hit;
    logic [31:0]        spd_raw;
    logic [2:0]         speed_nxt;
    logic [CNT_W:0]     new_score;

    seq_mem #(.COLOR_W(COLOR_W), .DEPTH(DEPTH)) u_mem (
        .CLK   (CLK),
        .we    (mem_we),
        .waddr (len[CNT_W-1:0]),
        .wdata (RAND),
        .raddr (idx),
        .rdata (mem_rd)
    );

    assign len_inc   = len + 1'b1;
    assign last      = ({1'b0, idx} == len - 1'b1);
    assign full      = (len == DEPTH_V);
    assign spd_raw   = 32'(len_inc) >> SPEED_SHIFT;
    assign speed_nxt = (spd_raw > 32'd7) ? SPEED_MAX : spd_raw[2:0];
    assign new_score = (state == ST_WIN) ? DEPTH_V : len - 1'b1;
    // A press in the same cycle as the final TICK wins over the timeout.
    assign timeout_hit = (TIMEOUT != 0) && TICK && !IN_VALID && (tcnt == TO_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        case (state)
            ST_IDLE:      if (START_GAME) state_nxt = ST_START;
            ST_START:     if (!START_GAME) state_nxt = ST_ADD;
            ST_ADD: begin
                if (full) begin
                    state_nxt = ST_WIN;
                end else begin
                    state_nxt = ST_SHOW;
                    mem_we    = 1'b1;
                end
            end
            ST_SHOW:      state_nxt = ST_SHOW_WAIT;
            ST_SHOW_WAIT: if (TIMER_PULSE) state_nxt = last ? ST_INPUT : ST_SHOW;
            ST_INPUT: begin
                if (IN_VALID)         state_nxt = ST_HOLD;
                else if (timeout_hit) state_nxt = ST_LOSE;
            end
            ST_HOLD: begin
                if (!IN_VALID) state_nxt = !good ? ST_LOSE : (last ? ST_ADD : ST_INPUT);
            end
            ST_WIN, ST_LOSE: state_nxt = ST_IDLE;
            default:         state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx        <= '0;
            len        <= '0;
            tcnt       <= '0;
            good       <= 1'b0;
            SPEED      <= '0;
            OUT        <= '1;
            OUT_ENA    <= 1'b0;
            TIMER_GO   <= 1'b0;
            SCORE      <= '0;
            HIGH_SCORE <= '0;
            WIN        <= 1'b0;
            LOSE       <= 1'b0;
            HS         <= 1'b0;
        end else begin
            TIMER_GO <= 1'b0;
            WIN      <= 1'b0;
            LOSE     <= 1'b0;
            HS       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    idx <= '0;
                    len <= '0;
                end
                ST_ADD: begin
                    if (!full) begin
                        len   <= len_inc;
                        idx   <= '0;
                        SPEED <= speed_nxt;
                    end
                end
                ST_SHOW: begin
                    OUT      <= mem_rd;
                    OUT_ENA  <= 1'b1;
                    TIMER_GO <= 1'b1;
                end
                ST_SHOW_WAIT: begin
                    if (TIMER_PULSE) begin
                        OUT_ENA <= 1'b0;
                        if (last) begin
                            idx  <= '0;
                            tcnt <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_INPUT: begin
                    if (IN_VALID) begin
                        good    <= (IN == mem_rd);
                        OUT     <= IN;
                        OUT_ENA <= 1'b1;
                    end else if (TICK && TIMEOUT != 0) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!IN_VALID) begin
                        OUT_ENA <= 1'b0;
                        if (good && !last) begin
                            idx  <= idx + 1'b1;
                            tcnt <= '0;
                        end
                    end
                end
                ST_WIN, ST_LOSE: begin
                    SCORE <= new_score;
                    WIN   <= (state == ST_WIN);
                    LOSE  <= (state == ST_LOSE);
                    if (new_score > HIGH_SCORE) begin
                        HIGH_SCORE <= new_score;
                        HS         <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
